// File: rtl/util_iic_slave_pkg.sv
// util_iic_slave_pkg: shared IIC FSM state encodings, ACK/NACK levels and
// pointer helper; usable by master-side IIC modules as well.
package util_iic_slave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_WAIT_STOP
  } iic_state_e;

  localparam logic IIC_ACK  = 1'b0;
  localparam logic IIC_NACK = 1'b1;

  // register pointer increment, wraps 8'hFF -> 8'h00
  function automatic logic [7:0] ptr_inc(input logic [7:0] a);
    return a + 8'd1;
  endfunction

endpackage

// File: rtl/util_iic_slave_if.sv
// util_iic_slave_if: simple_iic bus lines. *_i are line levels,
// *_o/*_ie are drives (ie=1 releases the line, ie=0 drives o).
interface util_iic_slave_if;
  logic scl_i;
  logic sda_i;
  logic scl_o;
  logic scl_ie;
  logic sda_o;
  logic sda_ie;

  modport slave (
    input  scl_i, sda_i,
    output scl_o, scl_ie, sda_o, sda_ie
  );

  modport master (
    output scl_i, sda_i,
    input  scl_o, scl_ie, sda_o, sda_ie
  );
endinterface

// File: rtl/util_iic_slave_filter.sv
// util_iic_filter: 2-FF synchroniser, FILTER_LEN glitch filter and edge
// pulses. Ports: clk, rstn, din (raw line), dout (filtered), rise, fall.
module util_iic_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt;

  // a new level is taken only after FILTER_LEN consecutive samples of it;
  // dout and its edge pulse update on the same clock
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= 2'b11;
      dout   <= 1'b1;
      cnt    <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], din};
      rise   <= 1'b0;
      fall   <= 1'b0;
      if (sync_q[1] == dout) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        cnt  <= '0;
        dout <= sync_q[1];
        rise <= sync_q[1];
        fall <= ~sync_q[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/util_iic_slave.sv
// util_iic_slave: IIC register-access slave. Ports: clk, rstn, iic (bus
// lines), reg_addr/reg_wr_en/reg_wr_data/reg_rd_req/reg_rd_data, busy.
module util_iic_slave
  import util_iic_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         FILTER_LEN = 3
) (
  input  logic                   clk,
  input  logic                   rstn,
  util_iic_slave_if.slave        iic,
  output logic [7:0]             reg_addr,
  output logic                   reg_wr_en,
  output logic [7:0]             reg_wr_data,
  output logic                   reg_rd_req,
  input  logic [7:0]             reg_rd_data,
  output logic                   busy
);

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;

  util_iic_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (
    .clk  (clk),
    .rstn (rstn),
    .din  (iic.scl_i),
    .dout (scl_f),
    .rise (scl_rise),
    .fall (scl_fall)
  );

  util_iic_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (
    .clk  (clk),
    .rstn (rstn),
    .din  (iic.sda_i),
    .dout (sda_f),
    .rise (sda_rise),
    .fall (sda_fall)
  );

  iic_state_e state;
  logic [3:0] bit_cnt;
  logic [7:0] rx;
  logic [7:0] tx;
  logic       rw;
  logic       first;
  logic       mack;
  logic       rd_latch;
  logic       sda_ie_q;

  // an SDA edge coinciding with an SCL edge is neither START nor STOP
  logic scl_edge, start_det, stop_det;
  assign scl_edge  = scl_rise | scl_fall;
  assign start_det = sda_fall & scl_f & ~scl_edge;
  assign stop_det  = sda_rise & scl_f & ~scl_edge;

  assign iic.scl_o  = 1'b1;
  assign iic.scl_ie = 1'b1;
  assign iic.sda_o  = 1'b0;
  assign iic.sda_ie = sda_ie_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      rx          <= '0;
      tx          <= '0;
      rw          <= 1'b0;
      first       <= 1'b0;
      mack        <= 1'b0;
      rd_latch    <= 1'b0;
      sda_ie_q    <= 1'b1;
      reg_addr    <= '0;
      reg_wr_en   <= 1'b0;
      reg_wr_data <= '0;
      reg_rd_req  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      reg_wr_en  <= 1'b0;
      reg_rd_req <= 1'b0;
      rd_latch   <= reg_rd_req;
      if (reg_wr_en)
        reg_addr <= ptr_inc(reg_addr);
      // read data arrives the cycle after the request; drive its MSB
      if (rd_latch && state == ST_RD_DATA) begin
        tx       <= reg_rd_data;
        sda_ie_q <= reg_rd_data[7];
      end
      if (stop_det) begin
        state    <= ST_IDLE;
        sda_ie_q <= 1'b1;
        busy     <= 1'b0;
      end else if (start_det) begin
        state    <= ST_ADDR;
        bit_cnt  <= '0;
        sda_ie_q <= 1'b1;
      end else begin
        unique case (state)
          ST_ADDR: begin
            if (scl_rise) begin
              rx      <= {rx[6:0], sda_f};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              if (rx[7:1] == SLAVE_ADDR) begin
                rw       <= rx[0];
                busy     <= 1'b1;
                sda_ie_q <= IIC_ACK;
                state    <= ST_ADDR_ACK;
              end else begin
                busy  <= 1'b0;
                state <= ST_WAIT_STOP;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              sda_ie_q <= 1'b1;
              if (rw) begin
                reg_rd_req <= 1'b1;
                state      <= ST_RD_DATA;
              end else begin
                first <= 1'b1;
                state <= ST_WR_DATA;
              end
            end
          end
          ST_WR_DATA: begin
            if (scl_rise) begin
              rx      <= {rx[6:0], sda_f};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt  <= '0;
              sda_ie_q <= IIC_ACK;
              state    <= ST_WR_ACK;
              if (first) begin
                reg_addr <= rx;
                first    <= 1'b0;
              end else begin
                reg_wr_en   <= 1'b1;
                reg_wr_data <= rx;
              end
            end
          end
          ST_WR_ACK: begin
            if (scl_fall) begin
              sda_ie_q <= 1'b1;
              state    <= ST_WR_DATA;
            end
          end
          ST_RD_DATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                bit_cnt  <= '0;
                sda_ie_q <= 1'b1;
                state    <= ST_RD_ACK;
              end else begin
                tx       <= {tx[6:0], 1'b0};
                sda_ie_q <= tx[6];
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_rise) begin
              mack <= sda_f;
            end else if (scl_fall) begin
              if (mack == IIC_NACK) begin
                state <= ST_WAIT_STOP;
              end else begin
                reg_addr   <= ptr_inc(reg_addr);
                reg_rd_req <= 1'b1;
                state      <= ST_RD_DATA;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_util_iic_slave.sv
// tb_util_iic_slave: directed IIC master sequences with a scoreboard
// for register write strobes and read requests.
module tb_util_iic_slave;
  import util_iic_slave_pkg::*;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic [7:0] reg_addr;
  logic       reg_wr_en;
  logic [7:0] reg_wr_data;
  logic       reg_rd_req;
  logic [7:0] reg_rd_data = 8'h00;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int n_wr = 0;
  int n_rd = 0;
  int n_drv = 0;

  logic [15:0] wr_q[$];
  logic [7:0]  rd_q[$];

  util_iic_slave_if bus ();

  assign bus.scl_i = m_scl & (bus.scl_ie | bus.scl_o);
  assign bus.sda_i = m_sda & (bus.sda_ie | bus.sda_o);

  util_iic_slave #(.SLAVE_ADDR(7'h50), .FILTER_LEN(3)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .iic         (bus),
    .reg_addr    (reg_addr),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_data (reg_wr_data),
    .reg_rd_req  (reg_rd_req),
    .reg_rd_data (reg_rd_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // register file model: read data = address + 1, one cycle later
  always @(posedge clk)
    if (reg_rd_req) reg_rd_data <= reg_addr + 8'd1;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (!bus.sda_ie) n_drv++;
      if (reg_wr_en) begin
        n_wr++;
        chk("wr_expected", 16'(wr_q.size() > 0), 16'd1);
        if (wr_q.size() > 0)
          chk("wr_addr_data", {reg_addr, reg_wr_data}, wr_q.pop_front());
      end
      if (reg_rd_req) begin
        n_rd++;
        chk("rd_expected", 16'(rd_q.size() > 0), 16'd1);
        if (rd_q.size() > 0)
          chk("rd_addr", 16'(reg_addr), 16'(rd_q.pop_front()));
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic i2c_start();
    clks(2);
    m_sda = 1'b1;
    clks(Q);
    m_scl = 1'b1;
    clks(Q);
    m_sda = 1'b0;
    clks(Q);
    m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    clks(2);
    m_sda = 1'b0;
    clks(Q);
    m_scl = 1'b1;
    clks(Q);
    m_sda = 1'b1;
    clks(Q);
  endtask

  task automatic bit_io(input logic b, input bit glitch, output logic r);
    clks(2);
    m_sda = b;
    clks(Q - 2);
    if (glitch) begin
      m_scl = 1'b1;
      clks(1);
      m_scl = 1'b0;
    end
    clks(Q);
    m_scl = 1'b1;
    clks(Q / 2);
    @(negedge clk);
    r = bus.sda_i;
    clks(Q / 2);
    m_scl = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] d, input bit glitch,
                         output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--)
      bit_io(d[i], glitch && i == 3, r);
    bit_io(1'b1, 1'b0, ack);
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, 1'b0, r);
      d[i] = r;
    end
    bit_io(mack, 1'b0, r);
  endtask

  logic       ack;
  logic       r;
  logic [7:0] d;
  int         snap_drv, snap_wr, snap_rd;
  bit         seen;

  initial begin
    clks(4);
    @(negedge clk);
    chk("rst_sda_ie", 16'(bus.sda_ie), 16'd1);
    chk("rst_scl_ie", 16'(bus.scl_ie), 16'd1);
    chk("rst_sda_o", 16'(bus.sda_o), 16'd0);
    chk("rst_reg_addr", 16'(reg_addr), 16'h00);
    chk("rst_wr", {7'd0, reg_wr_en, reg_wr_data}, 16'h0000);
    chk("rst_rd_req", 16'(reg_rd_req), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    rstn = 1'b1;
    clks(4);

    // multi-byte write
    i2c_start();
    wr_byte(8'hA0, 1'b0, ack);
    chk("w1_addr_ack", 16'(ack), 16'd0);
    chk("w1_busy", 16'(busy), 16'd1);
    wr_byte(8'h10, 1'b0, ack);
    chk("w1_ptr_ack", 16'(ack), 16'd0);
    wr_q.push_back(16'h10AA);
    wr_q.push_back(16'h11BB);
    wr_byte(8'hAA, 1'b0, ack);
    chk("w1_d0_ack", 16'(ack), 16'd0);
    wr_byte(8'hBB, 1'b0, ack);
    chk("w1_d1_ack", 16'(ack), 16'd0);
    i2c_stop();
    clks(4);
    chk("w1_final_addr", 16'(reg_addr), 16'h12);
    chk("w1_busy_end", 16'(busy), 16'd0);
    chk("w1_wr_count", 16'(n_wr), 16'd2);

    // pointer write, repeated START, two-byte read
    i2c_start();
    wr_byte(8'hA0, 1'b0, ack);
    wr_byte(8'h20, 1'b0, ack);
    chk("r1_ptr_ack", 16'(ack), 16'd0);
    i2c_start();
    rd_q.push_back(8'h20);
    rd_q.push_back(8'h21);
    wr_byte(8'hA1, 1'b0, ack);
    chk("r1_addr_ack", 16'(ack), 16'd0);
    rd_byte(1'b0, d);
    chk("r1_byte0", 16'(d), 16'h21);
    rd_byte(1'b1, d);
    chk("r1_byte1", 16'(d), 16'h22);
    clks(8);
    chk("r1_wait_stop", 16'(dut.state), 16'(ST_WAIT_STOP));
    chk("r1_rd_count", 16'(n_rd), 16'd2);
    i2c_stop();
    clks(4);
    chk("r1_idle", 16'(dut.state), 16'(ST_IDLE));

    // wrong address
    snap_drv = n_drv;
    snap_wr = n_wr;
    snap_rd = n_rd;
    i2c_start();
    wr_byte(8'hA2, 1'b0, ack);
    chk("na_addr_nack", 16'(ack), 16'd1);
    chk("na_busy", 16'(busy), 16'd0);
    wr_byte(8'h33, 1'b0, ack);
    chk("na_data_nack", 16'(ack), 16'd1);
    i2c_stop();
    chk("na_no_drive", 16'(n_drv - snap_drv), 16'd0);
    chk("na_no_strobe", 16'(n_wr - snap_wr + n_rd - snap_rd), 16'd0);

    // pointer wrap
    i2c_start();
    wr_byte(8'hA0, 1'b0, ack);
    wr_byte(8'hFF, 1'b0, ack);
    wr_q.push_back(16'hFF11);
    wr_q.push_back(16'h0022);
    wr_byte(8'h11, 1'b0, ack);
    wr_byte(8'h22, 1'b0, ack);
    chk("wrap_ack", 16'(ack), 16'd0);
    i2c_stop();
    chk("wrap_addr", 16'(reg_addr), 16'h01);

    // SCL glitch inside a data byte
    i2c_start();
    wr_byte(8'hA0, 1'b0, ack);
    wr_byte(8'h40, 1'b0, ack);
    wr_q.push_back(16'h405A);
    wr_byte(8'h5A, 1'b1, ack);
    chk("gl_ack", 16'(ack), 16'd0);
    i2c_stop();
    chk("gl_addr", 16'(reg_addr), 16'h41);

    // reset during a read byte while SDA is driven low
    i2c_start();
    wr_byte(8'hA0, 1'b0, ack);
    wr_byte(8'h30, 1'b0, ack);
    i2c_start();
    rd_q.push_back(8'h30);
    wr_byte(8'hA1, 1'b0, ack);
    for (int i = 0; i < 4; i++) bit_io(1'b1, 1'b0, r);
    seen = 1'b0;
    for (int i = 0; i < 4 * Q && !seen; i++) begin
      @(negedge clk);
      if (!bus.sda_ie) seen = 1'b1;
    end
    chk("rr_driven_low", 16'(seen), 16'd1);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1 chk("rr_async_release", 16'(bus.sda_ie), 16'd1);
    clks(3);
    @(negedge clk);
    chk("rr_state_idle", 16'(dut.state), 16'(ST_IDLE));
    chk("rr_busy_rst", 16'(busy), 16'd0);
    rstn = 1'b1;
    snap_drv = n_drv;
    for (int i = 0; i < 5; i++) bit_io(1'b1, 1'b0, r);
    chk("rr_no_drive", 16'(n_drv - snap_drv), 16'd0);
    chk("rr_ignored", 16'(dut.state), 16'(ST_IDLE));
    i2c_stop();
    i2c_start();
    wr_byte(8'hA0, 1'b0, ack);
    chk("rr_next_ack", 16'(ack), 16'd0);
    wr_byte(8'h05, 1'b0, ack);
    wr_q.push_back(16'h0577);
    wr_byte(8'h77, 1'b0, ack);
    i2c_stop();

    clks(4);
    chk("wr_q_drained", 16'(wr_q.size()), 16'd0);
    chk("rd_q_drained", 16'(rd_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
